// File: rtl/arb_req_collector_if.sv
// Bundle of request, grant and status signals between the collector and its
// environment (requesters + arbiter).
interface arb_req_collector_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 3
);
    logic [N-1:0]       req_pulse;
    logic [N-1:0]       gnt;
    logic               clr_err;
    logic [N-1:0]       req_out;
    logic [N-1:0]       ack;
    logic [N*CNT_W-1:0] pend_cnt;
    logic [N-1:0]       overflow;
    logic               gnt_err;

    modport master (
        output req_pulse, gnt, clr_err,
        input  req_out, ack, pend_cnt, overflow, gnt_err
    );

    modport slave (
        input  req_pulse, gnt, clr_err,
        output req_out, ack, pend_cnt, overflow, gnt_err
    );
endinterface

// File: rtl/arb_req_collector.sv
// Per-channel pending-request counters feeding a fixed-priority arbiter;
// retires one request per valid one-hot grant and flags overflow/bad grants.
module arb_req_collector #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    arb_req_collector_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [N-1:0][CNT_W-1:0] r_cnt;
    logic [N-1:0]            r_ack;
    logic [N-1:0]            r_overflow;
    logic                    r_gnt_err;

    logic [N-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [N-1:0]            w_dec;
    logic [N-1:0]            w_inc;
    logic [N-1:0]            w_drop;
    logic [N-1:0]            w_req_out;
    logic                    w_gnt_multi;
    logic                    w_gnt_onehot;

    // x & (x-1) clears the lowest set bit; non-zero result means multi-hot.
    always_comb begin
        w_gnt_multi  = (bus.gnt & (bus.gnt - N'(1))) != '0;
        w_gnt_onehot = (bus.gnt != '0) && !w_gnt_multi;
    end

    always_comb begin
        w_dec     = '0;
        w_inc     = '0;
        w_drop    = '0;
        w_req_out = '0;
        w_cnt_nxt = r_cnt;
        for (int unsigned i = 0; i < N; i++) begin
            w_req_out[i] = (r_cnt[i] != '0);
            w_dec[i]     = w_gnt_onehot & bus.gnt[i] & w_req_out[i];
            w_inc[i]     = bus.req_pulse[i] & ((r_cnt[i] != MAX) | w_dec[i]);
            w_drop[i]    = bus.req_pulse[i] & ~w_inc[i];
            case ({w_inc[i], w_dec[i]})
                2'b10:   w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
        end
    end

    // A same-cycle error event wins over clr_err so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_ack      <= '0;
            r_overflow <= '0;
            r_gnt_err  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ack      <= w_dec;
            r_overflow <= (r_overflow & ~{N{bus.clr_err}}) | w_drop;
            r_gnt_err  <= (r_gnt_err & ~bus.clr_err) | w_gnt_multi;
        end
    end

    always_comb begin
        bus.req_out  = w_req_out;
        bus.ack      = r_ack;
        bus.pend_cnt = r_cnt;
        bus.overflow = r_overflow;
        bus.gnt_err  = r_gnt_err;
    end
endmodule

// File: tb/tb_arb_req_collector.sv
// Directed bench for arb_req_collector: integer-count reference model checked
// every cycle, plus literal spot checks and a closed loop with a priority arbiter.
module tb_arb_req_collector;
    logic clk;
    logic rst;

    arb_req_collector_if #(.N(4), .CNT_W(3)) bus ();

    arb_req_collector #(.N(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    int   m_pend [4];
    logic [3:0] m_ack;
    logic [3:0] m_ovf;
    logic       m_gerr;

    bit   collect = 0;
    int   ack_q [$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer counts, updated from the sampled inputs.
    always @(posedge clk) begin
        int ones;
        ones = $countones(bus.gnt);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_ack  = '0;
            m_ovf  = '0;
            m_gerr = 1'b0;
        end else begin
            if (bus.clr_err) begin
                m_ovf  = '0;
                m_gerr = 1'b0;
            end
            if (ones > 1) m_gerr = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_ack[i] = (ones == 1) && bus.gnt[i] && (m_pend[i] > 0);
                if (bus.req_pulse[i]) begin
                    if (m_pend[i] < 7 || m_ack[i]) m_pend[i] = m_pend[i] + 1;
                    else m_ovf[i] = 1'b1;
                end
                if (m_ack[i]) m_pend[i] = m_pend[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] exp_pend;
        logic [3:0]  exp_req;
        for (int i = 0; i < 4; i++) begin
            exp_pend[i*3 +: 3] = 3'(m_pend[i]);
            exp_req[i]         = (m_pend[i] != 0);
        end
        check("model pend_cnt", 32'(bus.pend_cnt), 32'(exp_pend));
        check("model req_out",  32'(bus.req_out),  32'(exp_req));
        check("model ack",      32'(bus.ack),      32'(m_ack));
        check("model overflow", 32'(bus.overflow), 32'(m_ovf));
        check("model gnt_err",  32'(bus.gnt_err),  32'(m_gerr));
        if (collect)
            for (int i = 0; i < 4; i++)
                if (bus.ack[i]) ack_q.push_back(i);
    end

    task automatic step(input logic [3:0] r, input logic [3:0] g,
                        input logic c, input logic x);
        bus.req_pulse = r;
        bus.gnt       = g;
        bus.clr_err   = c;
        rst           = x;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.pend_cnt, bus.req_out, bus.ack, bus.overflow, bus.gnt_err}, '0);
    endtask

    initial begin
        logic [3:0] nxt;
        logic [3:0] g;
        logic [3:0] ro;
        int exp_order [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

        // Reset with busy inputs
        step(4'b1111, 4'b0001, 1'b0, 1'b1);
        check_all_zero("reset cycle1");
        step(4'b1111, 4'b0001, 1'b0, 1'b1);
        check_all_zero("reset cycle2");
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check_all_zero("post reset");

        // Single flow on channel 2, second grant cycle is stale
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        check("flow pend", 32'(bus.pend_cnt), 32'h040);
        check("flow req_out", 32'(bus.req_out), 32'h4);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("flow req_out hold", 32'(bus.req_out), 32'h4);
        step(4'b0000, 4'b0100, 1'b0, 1'b0);
        check("flow ack", 32'(bus.ack), 32'h4);
        check("flow pend0", 32'(bus.pend_cnt), 32'h000);
        step(4'b0000, 4'b0100, 1'b0, 1'b0);
        check("stale ack", 32'(bus.ack), 32'h0);
        check("stale gnt_err", 32'(bus.gnt_err), 32'h0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Simultaneous inc and dec on channel 1
        repeat (3) step(4'b0010, 4'b0000, 1'b0, 1'b0);
        check("simul pre", 32'(bus.pend_cnt), 32'h018);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("simul cnt", 32'(bus.pend_cnt), 32'h018);
        check("simul ack", 32'(bus.ack), 32'h2);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("simul ack drop", 32'(bus.ack), 32'h0);
        repeat (3) step(4'b0000, 4'b0010, 1'b0, 1'b0);
        check("simul drain", 32'(bus.pend_cnt), 32'h000);

        // Overflow on channel 0, then clear
        repeat (8) step(4'b0001, 4'b0000, 1'b0, 1'b0);
        check("ovf cnt", 32'(bus.pend_cnt), 32'h007);
        check("ovf flag", 32'(bus.overflow), 32'h1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("ovf clr", 32'(bus.overflow), 32'h0);
        check("ovf cnt kept", 32'(bus.pend_cnt), 32'h007);

        // Malformed grant with cnt0=2, cnt3=1
        repeat (5) step(4'b0000, 4'b0001, 1'b0, 1'b0);
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        check("bad pre", 32'(bus.pend_cnt), 32'h202);
        step(4'b0000, 4'b1001, 1'b0, 1'b0);
        check("bad cnt", 32'(bus.pend_cnt), 32'h202);
        check("bad ack", 32'(bus.ack), 32'h0);
        check("bad gnt_err", 32'(bus.gnt_err), 32'h1);
        step(4'b0000, 4'b1001, 1'b1, 1'b0);
        check("bad err wins clr", 32'(bus.gnt_err), 32'h1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("bad err cleared", 32'(bus.gnt_err), 32'h0);

        // Mid-operation reset discards pending requests without acks
        step(4'b0000, 4'b1000, 1'b0, 1'b1);
        check_all_zero("mid reset");
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check_all_zero("mid reset after");

        // Closed loop with a registered fixed-priority arbiter
        collect = 1;
        nxt = '0;
        for (int c = 0; c < 30; c++) begin
            g   = nxt;
            ro  = bus.req_out;
            nxt = ro & (~ro + 4'd1);
            step((c < 2) ? 4'b1111 : 4'b0000, g, 1'b0, 1'b0);
        end
        collect = 0;
        check("loop ack count", 32'(ack_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check("loop ack order", (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_order[i]));
        check("loop final pend", 32'(bus.pend_cnt), 32'h000);
        check("loop gnt_err", 32'(bus.gnt_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
